pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 4, meaning the register-address width.
REQ-002 The block SHALL have parameter MEM_TMO, default 15, meaning the maximum number of memory wait cycles before timeout (range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports id_src1 and id_src2, input, REG_AW bits each: ID-stage source registers.
REQ-006 The block SHALL have port id_two_src, input, 1 bit: id_src2 is valid.
REQ-007 The block SHALL have ports exe_dest (REG_AW), exe_wb_en (1) and exe_mem_read (1), inputs: the EXE-stage destination, its writeback enable and its load flag.
REQ-008 The block SHALL have ports mem_dest (REG_AW) and mem_wb_en (1), inputs: the MEM-stage destination and its writeback enable.
REQ-009 The block SHALL have port branch_taken, input, 1 bit: the EXE-stage branch resolved taken.
REQ-010 The block SHALL have ports mem_req (1) and mem_ready (1), inputs: a MEM-stage access is pending, and data memory completes it.
REQ-011 The block SHALL have ports freeze_if, freeze_id, freeze_exe and freeze_mem, outputs, 1 bit each: hold the corresponding stage register.
REQ-012 The block SHALL have ports flush_if and flush_id, outputs, 1 bit each: zero the IF/ID and ID/EXE stage registers.
REQ-013 The block SHALL have port mem_err, output, 1 bit: one-cycle timeout pulse.
REQ-014 The block SHALL have port stall_cnt, output, 16 bits: count of stalled cycles, saturating.

Function
REQ-015 The FSM SHALL have exactly three states, RUN, MEM_WAIT and TMO; reset state RUN.
REQ-016 RUN -> MEM_WAIT SHALL occur when mem_req=1 and mem_ready=0; MEM_WAIT -> RUN when mem_ready=1; MEM_WAIT -> TMO when the wait counter equals MEM_TMO; TMO -> RUN unconditionally after 1 cycle.
REQ-017 The wait counter SHALL be 8 bits, cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle, and never wrap.
REQ-018 A hazard SHALL exist when (exe_wb_en and exe_dest==id_src1) or (mem_wb_en and mem_dest==id_src1), or the same comparison against id_src2 gated by id_two_src.
REQ-019 In RUN with a hazard and branch_taken=0, the block SHALL assert freeze_if=1, freeze_id=1 and flush_id=1 (bubble), with all other outputs 0; these outputs SHALL be combinational, with zero-cycle latency.
REQ-020 In RUN with branch_taken=1, the block SHALL assert flush_if=1 and flush_id=1 and no freeze; the branch SHALL win over a simultaneous hazard.
REQ-021 In MEM_WAIT, the block SHALL assert all four freeze outputs and both flushes 0; a branch_taken arriving during the wait SHALL be deferred and applied in the RUN cycle after exit, since EXE is held.
REQ-022 In TMO, the block SHALL assert mem_err=1, flush_if=1 and flush_id=1, with freezes 0.
REQ-023 In the cycle that mem_req=1 and mem_ready=1 in RUN, the block SHALL not stall.
REQ-024 stall_cnt SHALL increment on each cycle in which any freeze output is 1, and saturate at 0xFFFF.

Reset
REQ-025 While rst=0, the block SHALL force the state to RUN, the wait counter to 0, stall_cnt to 0, all freeze and flush outputs to 0, and mem_err to 0, independent of the clock.
REQ-026 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after release, the block SHALL resume in RUN with no pending branch.

Configuration
REQ-027 With FORWARDING_EN defined, the hazard SHALL be limited to EXE load-use (exe_mem_read and exe_wb_en and a matching exe_dest), with MEM-stage matches ignored.
REQ-028 Without FORWARDING_EN, the hazard SHALL follow REQ-018 exactly.

Structure
REQ-029 A shared package SHALL hold the state enum (RUN, MEM_WAIT, TMO) and the default REG_AW.
REQ-030 The block SHALL contain one sub-module, hazard_detect (combinational comparator, REQ-018/027/028); the FSM, counters and output decode SHALL reside in pipe_hazard_ctrl.

Verification
REQ-031 Hazard: exe_wb_en=1, exe_dest=3, id_src1=3 -> freeze_if=freeze_id=flush_id=1 that cycle, stall_cnt=1 next cycle.
REQ-032 Branch+hazard: branch_taken=1 with the REQ-031 hazard -> flush_if=flush_id=1, freezes 0.
REQ-033 Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> all freezes 1 for 4 cycles, RUN after, stall_cnt=4.
REQ-034 Timeout: MEM_TMO=15, mem_ready held 0 -> mem_err=1 exactly one cycle after 15 wait cycles, then RUN.
REQ-035 Forwarding: FORWARDING_EN defined, mem_wb_en=1, mem_dest=5, id_src2=5, id_two_src=1 -> no stall; same case with the macro undefined -> stall.
REQ-036 Reset mid-wait: rst=0 during MEM_WAIT -> all outputs 0 immediately; state RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the controller state encoding and the default register-address width.
package pipe_hazard_ctrl_pkg;

    // Controller states: normal issue, waiting on data memory, timeout recovery.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TMO      = 2'd2
    } state_e;

    // Default register-address width (16 architectural registers).
    localparam int REG_AW_DEF = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational RAW hazard comparator for the ID stage.
// Optional feature macro: FORWARDING_EN. When defined, the EXE and MEM results
// are assumed to be forwarded, so only an EXE-stage load feeding the ID-stage
// instruction (load-use) still needs a bubble.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              hazard
);

    logic exe_hit;
    logic mem_hit;

    // Source-operand matches against each in-flight destination; src2 only counts when used.
    always_comb begin
        exe_hit = exe_wb_en && ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
        mem_hit = mem_wb_en && ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));
    end

`ifdef FORWARDING_EN
    // MEM-stage results are forwarded, so those matches are deliberately ignored.
    logic unused_mem_hit;
    assign unused_mem_hit = mem_hit;

    // Only a load in EXE cannot be forwarded in time.
    always_comb begin
        hazard = exe_hit && exe_mem_read;
    end
`else
    // Without forwarding the load flag is irrelevant: any writer in flight stalls.
    logic unused_mem_read;
    assign unused_mem_read = exe_mem_read;

    // Any pending writer of a source register forces a bubble.
    always_comb begin
        hazard = exe_hit || mem_hit;
    end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/flush control for a 5-stage pipeline.
// Combines ID-stage data hazards, taken branches and data-memory wait states
// into per-stage freeze and flush controls, with a memory-timeout recovery path
// and a saturating stalled-cycle counter.
// Optional feature macro: FORWARDING_EN (see hazard_detect).
//
// Memory handshake: mem_req is held high by the MEM stage while an access is
// outstanding; the access completes in the cycle mem_req and mem_ready are both
// high. A request that completes in its first cycle costs no stall; otherwise
// the whole pipe is frozen until mem_ready, or until MEM_TMO wait cycles elapse.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MEM_TMO = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              freeze_if,
    output logic              freeze_id,
    output logic              freeze_exe,
    output logic              freeze_mem,
    output logic              flush_if,
    output logic              flush_id,
    output logic              mem_err,
    output logic [15:0]       stall_cnt,
    output state_e            dbg_state
);

    state_e      state_q;
    state_e      state_d;
    logic [7:0]  wait_cnt_q;
    logic [7:0]  wait_inc;
    logic        tmo_hit;
    logic        branch_pend_q;
    logic        hazard;
    logic        any_freeze;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    // Wait-cycle count including the current MEM_WAIT cycle; holds at 255 instead of wrapping.
    always_comb begin
        wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        tmo_hit  = (wait_inc == 8'(MEM_TMO));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter: zeroed on entry to MEM_WAIT, advanced once per MEM_WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q != MEM_WAIT && state_d == MEM_WAIT) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q == MEM_WAIT) begin
            wait_cnt_q <= wait_inc;
        end
    end

    // A branch resolved while EXE is frozen is remembered and applied on the first RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_pend_q <= 1'b0;
        end else if (state_q == MEM_WAIT) begin
            branch_pend_q <= branch_pend_q | branch_taken;
        end else begin
            branch_pend_q <= 1'b0;
        end
    end

    // Next-state and output decode; outputs are zero-latency and forced low during reset.
    always_comb begin
        state_d    = state_q;
        freeze_if  = 1'b0;
        freeze_id  = 1'b0;
        freeze_exe = 1'b0;
        freeze_mem = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken || branch_pend_q) begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end else if (hazard) begin
                    freeze_if = 1'b1;
                    freeze_id = 1'b1;
                    flush_id  = 1'b1;
                end
                if (mem_req && !mem_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                freeze_if  = 1'b1;
                freeze_id  = 1'b1;
                freeze_exe = 1'b1;
                freeze_mem = 1'b1;
                if (mem_ready) begin
                    state_d = RUN;
                end else if (tmo_hit) begin
                    state_d = TMO;
                end
            end
            TMO: begin
                mem_err  = 1'b1;
                flush_if = 1'b1;
                flush_id = 1'b1;
                state_d  = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!rst) begin
            freeze_if  = 1'b0;
            freeze_id  = 1'b0;
            freeze_exe = 1'b0;
            freeze_mem = 1'b0;
            flush_if   = 1'b0;
            flush_id   = 1'b0;
            mem_err    = 1'b0;
        end
    end

    // Any frozen stage counts as a stalled cycle.
    always_comb begin
        any_freeze = freeze_if | freeze_id | freeze_exe | freeze_mem;
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if (any_freeze && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Expose the controller state for observation.
    always_comb begin
        dbg_state = state_q;
    end

endmodule
